regfile_sb: RTL

// - Parametrised integer register file for the rv32i datapath: 2 async read ports, 1 sync write port.
// - Adds a per-register busy scoreboard (set at issue, cleared at writeback) producing read-hazard flags.
// - Adds a sequential post-reset clear engine: one entry zeroed per cycle, then init_done.
// - Sits between decode (ra1/ra2/issue) and writeback (we/wa/wd).

---
 rtl/regfile_sb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: rv32i integer register file with two combinational read ports,
// one synchronous write port, a per-register busy scoreboard that raises read
// hazard flags, and a post-reset engine that zeroes one entry per cycle.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward the in-flight
// writeback data (and suppress the hazard) to a read port on an address match.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            haz1,
  output logic            haz2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            init_done
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CLR_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CLR_ONE  = (AW+1)'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW:0]     clr_cnt;
  logic [AW:0]     clr_cnt_nxt;
  logic            init_done_nxt;
  logic [XLEN-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic            ready;
  logic            wr_en;
  logic            iss_en;
  logic            byp1;
  logic            byp2;

  // True when the address names the hardwired zero register.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign ready  = (state == READY);
  assign wr_en  = ready && we && !is_zero(wa);
  assign iss_en = ready && issue_valid && !is_zero(issue_rd);

`ifdef REGFILE_SB_BYPASS_EN
  assign byp1 = wr_en && (wa == ra1);
  assign byp2 = wr_en && (wa == ra2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Next-state logic: walk the clear counter across every entry, then park in READY.
  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    init_done_nxt = init_done;
    if (state == CLEAR) begin
      clr_cnt_nxt = clr_cnt + CLR_ONE;
      if (clr_cnt == CLR_LAST) begin
        state_nxt     = READY;
        init_done_nxt = 1'b1;
      end
    end
  end

  // Control state register; reset restarts the clear sequence from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      init_done <= init_done_nxt;
    end
  end

  // Busy scoreboard: writeback clears, issue sets; issue is applied last so a
  // same-edge collision leaves the newer producer pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wr_en) busy[wa] <= 1'b0;
      if (iss_en) busy[issue_rd] <= 1'b1;
    end
  end

  // Storage: zeroed one entry per cycle while clearing, written by writeback once ready.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_cnt[AW-1:0]] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wd;
    end
  end

  // Read port 1: zero while clearing or on x0, forwarded data on bypass, else storage.
  always_comb begin
    rd1  = '0;
    haz1 = 1'b0;
    if (ready && !is_zero(ra1)) begin
      if (byp1) begin
        rd1 = wd;
      end else begin
        rd1  = mem[ra1];
        haz1 = busy[ra1];
      end
    end
  end

  // Read port 2: identical behaviour to port 1.
  always_comb begin
    rd2  = '0;
    haz2 = 1'b0;
    if (ready && !is_zero(ra2)) begin
      if (byp2) begin
        rd2 = wd;
      end else begin
        rd2  = mem[ra2];
        haz2 = busy[ra2];
      end
    end
  end

endmodule
